grf_sb: RTL and testbench
=========================

# grf_sb

General register file for the five-stage MIPS pipeline, combined with a per-register pending-write scoreboard. It is the receiving end of the writeback interface: the W stage drives write address, write data and write enable into it, and the D stage reads operands and a stall request from it. The block stores 32 × 32-bit registers, with `$0` hardwired to zero. It counts in-flight writers per register so that D stalls until a pending result has been written back.

## Interface
- `NREG`, default 32: number of architectural registers. Fixed at 32; address width is 5.
- `CNTW`, default 2: width of the per-register in-flight counter. The maximum count is 3, covering writers in E, M and W.
- `clk` in 1: single clock. All state updates on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `A1` in 5: D-stage read address for port 1 (rs).
- `A2` in 5: D-stage read address for port 2 (rt).
- `use1` in 1: D instruction actually consumes `A1`.
- `use2` in 1: D instruction actually consumes `A2`.
- `RD1` out 32: read data for port 1.
- `RD2` out 32: read data for port 2.
- `A3` in 5: W-stage write address, driven from W's A3 mux output.
- `WD` in 32: W-stage write data.
- `RegWrite` in 1: W-stage write enable.
- `issue_en` in 1: an instruction with a destination register leaves D this cycle.
- `issue_addr` in 5: destination register of that instruction.
- `stall` out 1: D must hold this cycle.
- `sb_err` out 1: sticky scoreboard protocol error flag.

## Operation
- Register storage:
  - Reads are combinational.
  - `RD1` is `reg[A1]`, and `RD2` is `reg[A2]`.
  - Any read of address 0 returns 0.
- Writes:
  - When `RegWrite` is 1 and `A3` ≠ 0, `reg[A3]` takes `WD` at the clock edge.
  - Writes with `A3` = 0 are ignored.
- Scoreboard keeps `cnt[r]` for r = 1..31. `cnt[0]` is constant 0.
  - Increment `cnt[r]` when `issue_en` is 1 and `issue_addr` = r ≠ 0.
  - Decrement `cnt[r]` when `RegWrite` is 1 and `A3` = r ≠ 0.
  - If the increment and the decrement hit the same r in the same cycle, `cnt[r]` is unchanged.
- `busy(r)` is true when `cnt[r]` ≠ 0.
- `stall` is 1 when either condition holds:
  - `use1` is 1, `A1` ≠ 0 and `busy(A1)`, with no bypass exemption.
  - The same condition for `use2` and `A2`.
- `issue_en` is qualified externally by `!stall`. When `stall` is 1, the block ignores `issue_en`.
- Error conditions: the affected counter saturates or floors, and `sb_err` goes to 1 and stays set until reset.
  - Issue to r while `cnt[r]` = 3, with no simultaneous retire of r: the counter saturates at 3.
  - Retire to r while `cnt[r]` = 0: the counter stays at 0.

## Timing
- Reset, on a rising edge with `rst_n` = 0:
  - All 32 registers are cleared to 0, and all counters to 0.
  - `sb_err` is cleared to 0.
  - Ports `RD1`/`RD2` and `stall` therefore read 0 from the next cycle, and `sb_err` reads 0.
- Reset mid-operation discards all pending counts. Writes presented in the reset cycle are dropped.
- Read latency is 0 cycles (combinational).
- Without bypass, a W-stage write is visible on `RD*` in the cycle after the edge.
- Scoreboard timing:
  - Counter changes are visible to `stall` in the cycle after the triggering edge.
  - An issue in cycle t stalls a dependent D instruction from t+1.
  - A retire in cycle t releases the stall at t+1 if the count reached 0.

## Configuration
- `GRF_BYPASS_EN` defined enables same-cycle write-to-read bypass:
  - If `RegWrite` is 1 and `A3` = `A1` ≠ 0, then `RD1` = `WD`. The same applies to `RD2` with `A2`.
  - The stall term for a port is suppressed when that port's address equals the retiring `A3` and its count is 1.
- `GRF_BYPASS_EN` undefined:
  - No bypass path exists.
  - The stall holds through the retire cycle and releases one cycle later.

## Structure
- A shared package `mips_pkg` holds:
  - `REG_ZERO` = 5'd0, `NREG`, and `CNTW`.
  - A typedef for the 5-bit register address and the 32-bit word.
- One sub-module is natural: `sb_counter`, a per-register saturating up/down counter with error output. It is instantiated 31 times via generate.
- Register storage and read muxing live in the top level.

## Test plan
- Reset: hold `rst_n`=0 for one edge, then read `A1`=5 and `A2`=31. Required: `RD1`=`RD2`=0, `stall`=0, `sb_err`=0.
- Write/read: present `RegWrite`=1, `A3`=8, `WD`=32'hDEADBEEF. Next cycle `A1`=8 gives `RD1`=32'hDEADBEEF. A write to `A3`=0 leaves `RD*`(0)=0.
- RAW stall: issue `issue_addr`=9. Next cycle `A1`=9 with `use1`=1 gives `stall`=1.
  - After `RegWrite`, `A3`=9, `stall` drops the following cycle when bypass is off.
  - With `GRF_BYPASS_EN`, `stall` drops in the retire cycle and `RD1`=`WD`.
- `use` gating: `cnt[4]`=1, `A2`=4, `use2`=0 gives `stall`=0.
- Simultaneous issue and retire: with `cnt[3]`=1, issue and retire r=3 in the same cycle. `cnt[3]` stays 1 and `stall` stays 1.
- Errors: four issues to r=2 with no retire set `sb_err`=1 and hold `cnt[2]`=3. A retire to r=7 with `cnt[7]`=0 also sets `sb_err`. Reset clears `sb_err`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants for the register file / scoreboard.
package mips_pkg;
    localparam int NREG = 32;
    localparam int CNTW = 2;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/sb_counter.sv
// Per-register in-flight writer counter: saturating up/down with an error pulse
// when an increment hits the ceiling or a decrement hits the floor.
module sb_counter
    import mips_pkg::*;
#(
    parameter int CNTW = mips_pkg::CNTW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            dec,
    output logic [CNTW-1:0] cnt,
    output logic            err
);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [CNTW-1:0] cnt_d, cnt_q;

    // Next count; simultaneous issue and retire cancel out.
    always_comb begin
        cnt_d = cnt_q;
        err   = 1'b0;
        case ({inc, dec})
            2'b10: begin
                if (cnt_q == CNT_MAX) err = 1'b1;
                else                  cnt_d = cnt_q + 1'b1;
            end
            2'b01: begin
                if (cnt_q == '0) err = 1'b1;
                else             cnt_d = cnt_q - 1'b1;
            end
            default: ;
        endcase
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/grf_sb.sv
// General register file with per-register pending-write scoreboard.
// Optional macro GRF_BYPASS_EN: same-cycle W->D bypass on both read ports and
// release of the stall in the retire cycle when the retiring write is the
// last one in flight.
module grf_sb
    import mips_pkg::*;
#(
    parameter int NREG = mips_pkg::NREG,
    parameter int CNTW = mips_pkg::CNTW
) (
    input  logic      clk,
    input  logic      rst_n,
    input  reg_addr_t A1,
    input  reg_addr_t A2,
    input  logic      use1,
    input  logic      use2,
    output word_t     RD1,
    output word_t     RD2,
    input  reg_addr_t A3,
    input  word_t     WD,
    input  logic      RegWrite,
    input  logic      issue_en,
    input  reg_addr_t issue_addr,
    output logic      stall,
    output logic      sb_err
);
    localparam logic [CNTW-1:0] CNT_ONE = 1;

    word_t regs_d [NREG];
    word_t regs_q [NREG];

    logic [NREG-1:0][CNTW-1:0] cnt;
    logic [NREG-1:0]           cnt_err;
    logic                      wr_en, issue_ok;
    logic                      stall1, stall2;
    logic                      sb_err_d, sb_err_q;

    assign wr_en    = RegWrite && (A3 != REG_ZERO);
    // Issues presented while D is held are not real issues.
    assign issue_ok = issue_en && !stall;

    // Register file next state: single W-stage write port, $0 never written.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[A3] = WD;
    end

    // Register storage; reset clears all entries and drops a same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational read muxes with $0 forced to zero.
    always_comb begin
        RD1 = (A1 == REG_ZERO) ? '0 : regs_q[A1];
        RD2 = (A2 == REG_ZERO) ? '0 : regs_q[A2];
`ifdef GRF_BYPASS_EN
        if (wr_en && (A3 == A1)) RD1 = WD;
        if (wr_en && (A3 == A2)) RD2 = WD;
`endif
    end

    // One counter per architectural register except $0.
    assign cnt[0]     = '0;
    assign cnt_err[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        logic inc, dec;
        assign inc = issue_ok && (issue_addr == 5'(r));
        assign dec = wr_en && (A3 == 5'(r));

        sb_counter #(.CNTW(CNTW)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc),
            .dec   (dec),
            .cnt   (cnt[r]),
            .err   (cnt_err[r])
        );
    end

    // RAW hazard detection per read port.
    always_comb begin
        stall1 = use1 && (A1 != REG_ZERO) && (cnt[A1] != '0);
        stall2 = use2 && (A2 != REG_ZERO) && (cnt[A2] != '0);
`ifdef GRF_BYPASS_EN
        // The last outstanding writer is retiring now and bypassed onto the port.
        if (wr_en && (A3 == A1) && (cnt[A1] == CNT_ONE)) stall1 = 1'b0;
        if (wr_en && (A3 == A2) && (cnt[A2] == CNT_ONE)) stall2 = 1'b0;
`endif
        stall = stall1 || stall2;
    end

    // Sticky protocol error.
    always_comb begin
        sb_err_d = sb_err_q || (|cnt_err);
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) sb_err_q <= 1'b0;
        else        sb_err_q <= sb_err_d;
    end

    assign sb_err = sb_err_q;
endmodule

// File: tb/tb_grf_sb.sv
// Directed bench for grf_sb: reset, write/read, RAW stall timing, use gating,
// issue during stall, simultaneous issue/retire, saturation/floor errors.
module tb_grf_sb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  A1, A2, A3, issue_addr;
    logic        use1, use2, RegWrite, issue_en;
    logic [31:0] WD, RD1, RD2;
    logic        stall, sb_err;

    int n_chk  = 0;
    int n_fail = 0;

    grf_sb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A1         (A1),
        .A2         (A2),
        .use1       (use1),
        .use2       (use2),
        .RD1        (RD1),
        .RD2        (RD2),
        .A3         (A3),
        .WD         (WD),
        .RegWrite   (RegWrite),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .stall      (stall),
        .sb_err     (sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; A1 = '0; A2 = '0; A3 = '0; issue_addr = '0;
        use1 = 1'b0; use2 = 1'b0; RegWrite = 1'b0; issue_en = 1'b0; WD = '0;
        tick();
        rst_n = 1'b1; A1 = 5'd5; A2 = 5'd31;
        settle();
        chk("rst_rd1", RD1, 32'h0);
        chk("rst_rd2", RD2, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_err", {31'b0, sb_err}, 32'h0);

        // write 8 (issued first so the retire is legal), then ignored write to $0
        issue_en = 1'b1; issue_addr = 5'd8;
        tick();
        issue_en = 1'b0; RegWrite = 1'b1; A3 = 5'd8; WD = 32'hDEADBEEF;
        tick();
        A3 = 5'd0; WD = 32'h12345678; A1 = 5'd8; A2 = 5'd8;
        settle();
        chk("wr_rd1", RD1, 32'hDEADBEEF);
        chk("wr_rd2", RD2, 32'hDEADBEEF);
        tick();
        RegWrite = 1'b0; A1 = 5'd0;
        settle();
        chk("zero_rd1", RD1, 32'h0);
        chk("wr_err", {31'b0, sb_err}, 32'h0);

        // RAW on 9
        issue_en = 1'b1; issue_addr = 5'd9;
        tick();
        issue_en = 1'b0; A1 = 5'd9; use1 = 1'b1;
        settle();
        chk("raw_stall", {31'b0, stall}, 32'h1);
        RegWrite = 1'b1; A3 = 5'd9; WD = 32'hCAFEF00D;
        settle();
`ifdef GRF_BYPASS_EN
        chk("raw_retire_stall", {31'b0, stall}, 32'h0);
        chk("raw_bypass_rd1", RD1, 32'hCAFEF00D);
`else
        chk("raw_retire_stall", {31'b0, stall}, 32'h1);
`endif
        tick();
        RegWrite = 1'b0;
        settle();
        chk("raw_release", {31'b0, stall}, 32'h0);
        chk("raw_rd1", RD1, 32'hCAFEF00D);

        // issue presented while stalled is ignored
        issue_en = 1'b1; issue_addr = 5'd10;
        tick();
        A1 = 5'd10; issue_addr = 5'd11;
        settle();
        chk("hold_stall", {31'b0, stall}, 32'h1);
        tick();
        issue_en = 1'b0; use1 = 1'b0; RegWrite = 1'b1; A3 = 5'd10; WD = 32'h0000000A;
        tick();
        RegWrite = 1'b0; use1 = 1'b1; A1 = 5'd11;
        settle();
        chk("ignored_issue", {31'b0, stall}, 32'h0);
        A1 = 5'd10;
        settle();
        chk("r10_free", {31'b0, stall}, 32'h0);
        use1 = 1'b0;

        // use gating on port 2
        issue_en = 1'b1; issue_addr = 5'd4;
        tick();
        issue_en = 1'b0; A2 = 5'd4; use2 = 1'b0;
        settle();
        chk("use2_off", {31'b0, stall}, 32'h0);
        use2 = 1'b1;
        settle();
        chk("use2_on", {31'b0, stall}, 32'h1);
        use2 = 1'b0; RegWrite = 1'b1; A3 = 5'd4; WD = 32'h44;
        tick();
        RegWrite = 1'b0;

        // simultaneous issue and retire of 3
        issue_en = 1'b1; issue_addr = 5'd3;
        tick();
        RegWrite = 1'b1; A3 = 5'd3; WD = 32'h33;
        tick();
        issue_en = 1'b0; RegWrite = 1'b0; A1 = 5'd3; use1 = 1'b1;
        settle();
        chk("simul_stall", {31'b0, stall}, 32'h1);
        RegWrite = 1'b1; A3 = 5'd3;
        tick();
        RegWrite = 1'b0;
        settle();
        chk("simul_release", {31'b0, stall}, 32'h0);
        chk("simul_err", {31'b0, sb_err}, 32'h0);
        use1 = 1'b0;

        // saturation on 2
        issue_addr = 5'd2;
        for (int i = 0; i < 4; i++) begin
            issue_en = 1'b1;
            tick();
            issue_en = 1'b0;
            settle();
            if (i == 2) chk("sat_err_pre", {31'b0, sb_err}, 32'h0);
        end
        chk("sat_err", {31'b0, sb_err}, 32'h1);
        RegWrite = 1'b1; A3 = 5'd2; WD = 32'h22;
        tick();
        tick();
        RegWrite = 1'b0; A1 = 5'd2; use1 = 1'b1;
        settle();
        chk("sat_cnt_1left", {31'b0, stall}, 32'h1);
        RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0;
        settle();
        chk("sat_cnt_empty", {31'b0, stall}, 32'h0);
        use1 = 1'b0;

        // reset clears error, drops concurrent write and issue
        rst_n = 1'b0; RegWrite = 1'b1; A3 = 5'd12; WD = 32'hBADBAD00;
        issue_en = 1'b1; issue_addr = 5'd12;
        tick();
        rst_n = 1'b1; RegWrite = 1'b0; issue_en = 1'b0;
        A1 = 5'd12; use1 = 1'b1; A2 = 5'd8;
        settle();
        chk("rst2_err", {31'b0, sb_err}, 32'h0);
        chk("rst2_drop_wr", RD1, 32'h0);
        chk("rst2_clr_rd2", RD2, 32'h0);
        chk("rst2_no_cnt", {31'b0, stall}, 32'h0);
        use1 = 1'b0;

        // floor error on 7
        RegWrite = 1'b1; A3 = 5'd7; WD = 32'h77;
        tick();
        RegWrite = 1'b0;
        settle();
        chk("floor_err", {31'b0, sb_err}, 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        chk("rst3_err", {31'b0, sb_err}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
